// File: rtl/wb_shared_mem_responder.sv
// Shared program/data RAM responder for the J1 CPU cluster.
// Round-robin arbitrates the data and instruction ports of every CPU and
// serves one word access at a time from a single-port RAM. Each access takes
// IDLE -> ACCESS -> RESP; the winner gets a one-cycle ack in RESP with the
// response data valid in that same cycle.
module wb_shared_mem_responder #(
  parameter int NUM_CPU = 4,
  parameter int ADDR_W  = 12,
  parameter int PC_W    = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CPU-1:0]      d_cyc_i,
  input  logic [NUM_CPU-1:0]      d_we_i,
  input  logic [NUM_CPU*32-1:0]   d_adr_i,
  input  logic [NUM_CPU*32-1:0]   d_dat_i,
  output logic [NUM_CPU-1:0]      d_ack_o,
  output logic [31:0]             d_dat_o,
  input  logic [NUM_CPU-1:0]      i_cyc_i,
  input  logic [NUM_CPU*PC_W-1:0] i_pc_i,
  output logic [NUM_CPU-1:0]      i_ack_o,
  output logic [31:0]             i_dat_o,
  output logic                    busy_o
);

  localparam int DATA_W = 32;
  localparam int R      = 2 * NUM_CPU;
  localparam int IDX_W  = (R > 1) ? $clog2(R) : 1;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Round-robin pointer: the index searched first in the next IDLE cycle.
  logic [IDX_W-1:0] ptr;

  // Flattened requester view: even index = data port, odd index = fetch port.
  logic [R-1:0]      req;
  logic [ADDR_W-1:0] req_adr [R];
  logic              req_we  [R];
  logic [DATA_W-1:0] req_dat [R];

  // Arbitration result for the current IDLE cycle.
  logic             any_req;
  logic [IDX_W-1:0] win_idx;

  // Transaction captured on the IDLE edge.
  logic [IDX_W-1:0]  win_idx_p1;
  logic [ADDR_W-1:0] adr_p1;
  logic              we_p1;
  logic [DATA_W-1:0] dat_p1;

  // Response word captured on the ACCESS edge.
  logic [DATA_W-1:0] resp_dat_p2;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-offset and high address bits are intentionally ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{d_adr_i, i_pc_i};

  // Modulo-R increment of a requester index.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(R - 1)) begin
      return '0;
    end
    return i + IDX_W'(1);
  endfunction

  // Unpack the per-CPU buses into one requester array.
  always_comb begin
    req = '0;
    for (int k = 0; k < NUM_CPU; k++) begin
      req[2*k]       = d_cyc_i[k];
      req_adr[2*k]   = d_adr_i[32*k+2 +: ADDR_W];
      req_we[2*k]    = d_we_i[k];
      req_dat[2*k]   = d_dat_i[32*k +: DATA_W];
      req[2*k+1]     = i_cyc_i[k];
      req_adr[2*k+1] = i_pc_i[PC_W*k +: ADDR_W];
      req_we[2*k+1]  = 1'b0;
      req_dat[2*k+1] = '0;
    end
  end

  // Pick the first pending requester at or above ptr, wrapping modulo R.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    any_req = |req;
    win_idx = '0;
    found   = 1'b0;
    cand    = ptr;
    for (int i = 0; i < R; i++) begin
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
      cand = next_idx(cand);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; RESP always returns to IDLE for re-arbitration.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = any_req ? ACCESS : IDLE;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: one-hot ack to the latched winner during RESP.
  always_comb begin
    d_ack_o = '0;
    i_ack_o = '0;
    busy_o  = (state != IDLE);
    if (state == RESP) begin
      for (int k = 0; k < NUM_CPU; k++) begin
        d_ack_o[k] = (win_idx_p1 == IDX_W'(2*k));
        i_ack_o[k] = (win_idx_p1 == IDX_W'(2*k+1));
      end
    end
  end

  // Advance the round-robin pointer past the winner once it is served.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == ACCESS) begin
      ptr <= next_idx(win_idx_p1);
    end
  end

  // ---- stage p1: capture the winning request on the IDLE edge ----
  // Latch the winner; later changes on its request lines are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      win_idx_p1 <= win_idx;
      adr_p1     <= req_adr[win_idx];
      we_p1      <= req_we[win_idx];
      dat_p1     <= req_dat[win_idx];
    end
  end

  // ---- stage p2: RAM operation on the ACCESS edge ----
  // Single-port RAM write; suppressed when reset aborts the access.
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_p1 && !rst) begin
      mem[adr_p1] <= dat_p1;
    end
  end

  // Response register: echoes write data, or returns the addressed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_dat_p2 <= '0;
    end else if (state == ACCESS) begin
      resp_dat_p2 <= we_p1 ? dat_p1 : mem[adr_p1];
    end
  end

  assign d_dat_o = resp_dat_p2;
  assign i_dat_o = resp_dat_p2;

endmodule

// File: doc/wb_shared_mem_responder.md
# wb_shared_mem_responder

Wishbone-style responder owning the shared program/data RAM that all J1 CPU slaves reach through their `cyc_o/adr_o/dat_o/we_o/ack_i` data port and their `inst_cyc_o/inst_pc_o/inst_ack_i/inst_i` instruction port. It round-robin arbitrates among `2*NUM_CPU` requesters and serves one access at a time from a single-port synchronous RAM. It returns a one-cycle ack pulse to the winning requester, with read data valid in the same cycle.

## Interface
- `NUM_CPU`, default 4: number of CPU slaves attached; requester count `R = 2*NUM_CPU`.
- `ADDR_W`, default 12: RAM word-address width; depth `2**ADDR_W` words of 32 bits.
- `PC_W`, default 14: instruction PC width, in words.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `d_cyc_i`  in  NUM_CPU  per-CPU data request, level.
- `d_we_i`  in  NUM_CPU  per-CPU write enable; 1 = write, 0 = read.
- `d_adr_i`  in  NUM_CPU*32  per-CPU byte address; CPU k occupies bits `[32k+31:32k]`.
- `d_dat_i`  in  NUM_CPU*32  per-CPU write data, packed the same way as `d_adr_i`.
- `d_ack_o`  out  NUM_CPU  per-CPU data ack, one-cycle pulse.
- `d_dat_o`  out  32  read data, shared by all CPUs; valid while any `d_ack_o` bit is 1.
- `i_cyc_i`  in  NUM_CPU  per-CPU instruction fetch request.
- `i_pc_i`  in  NUM_CPU*PC_W  per-CPU fetch word address, packed.
- `i_ack_o`  out  NUM_CPU  per-CPU fetch ack, one-cycle pulse.
- `i_dat_o`  out  32  fetched instruction, shared; valid while any `i_ack_o` bit is 1.
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Requester index numbering:
  - data port of CPU k = 2k;
  - instruction port of CPU k = 2k+1.
- RAM word index:
  - data accesses use `d_adr_i[ADDR_W+1:2]`;
  - fetches use `i_pc_i[ADDR_W-1:0]`;
  - higher address bits are ignored, so addresses alias.
- Instruction requests are always reads.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request bit is set, select the winner: the first set bit searching upward from `ptr`, modulo R.
  - Latch the winner's index, word address, `we` and write data.
  - Go to ACCESS. With no request, stay in IDLE.
- ACCESS:
  - Perform the RAM operation on the clock edge that ends this state.
  - Write: the RAM word takes the latched data, and the response data register takes the same value.
  - Read: the response data register takes the RAM word.
  - Update `ptr` to (winner+1) mod R. Go to RESP.
- RESP:
  - Exactly one ack bit is 1: `d_ack_o[k]` if the winner is 2k, `i_ack_o[k]` if the winner is 2k+1.
  - Both `d_dat_o` and `i_dat_o` drive the response register.
  - Go to IDLE.
- Requests are not re-checked after they are latched. If a requester drops `cyc` during ACCESS, the access still completes and is still acked.
- `d_dat_o` and `i_dat_o` hold their last value outside RESP.

## Timing
- Reset values:
  - all `d_ack_o` and `i_ack_o` bits 0;
  - `d_dat_o` and `i_dat_o` 0;
  - `busy_o` 0; FSM in IDLE; `ptr` 0.
- Reset does not clear RAM contents.
- `rst` mid-transaction:
  - It aborts on the next edge: no ack is issued and the FSM returns to IDLE.
  - A write whose ACCESS edge coincides with `rst` high is not performed.
- Latency: a request sampled in IDLE at edge t gets its ack during cycle t+2 (ACCESS is cycle t+1, RESP is cycle t+2).
- Throughput: one access per 3 cycles, because RESP always returns to IDLE.
- The IDLE cycle after RESP sees the acked requester's new request level. A CPU that issues back-to-back accesses is therefore re-arbitrated normally.
- A requester holding `cyc` receives no service until it wins. With all R requesting continuously, each is served once every 3R cycles.
- Simultaneous read and write requests from different CPUs are ordered strictly by round robin. A later read sees an earlier write.

## Test plan
- Single read:
  - Preload RAM[5]=32'hDEADBEEF.
  - Assert `d_cyc_i[0]` with `d_adr_i[31:0]`=32'h14 for one IDLE edge.
  - Required: `d_ack_o[0]` high exactly in cycle t+2, `d_dat_o`=32'hDEADBEEF, no other ack bit set.
- Write then read:
  - CPU1 writes 32'h12345678 to byte address 32'h40.
  - Then CPU1 fetches with PC 14'h10.
  - Required: `d_ack_o[1]` pulse with `d_dat_o`=32'h12345678, then `i_ack_o[1]` with `i_dat_o`=32'h12345678.
- Round robin:
  - NUM_CPU=4, all 8 requests held from reset release.
  - Required: acks in index order 0,1,…,7,0, one every 3 cycles.
  - Required: after `ptr`=3, a request set only on index 2 is still served.
- Aliasing:
  - Fetch with PC 14'h1005 when RAM[5]=32'hA5A5A5A5.
  - Required: `i_dat_o`=32'hA5A5A5A5.
- Reset mid-op:
  - Assert `rst` during ACCESS of a write to RAM[7], which previously held 32'h0.
  - Required: no ack, `busy_o`=0 next cycle, and a later read of RAM[7] returns 32'h0.
- Dropped request:
  - Deassert `d_cyc_i[2]` during ACCESS.
  - Required: `d_ack_o[2]` still pulses once, and the FSM returns to IDLE.
